// File: rtl/conversion_pkg.sv
// Shared widths, FSM state encoding and length helper for the DDR-to-CCSDS read path.
package conversion_pkg;

  localparam int DDR_W   = 256;
  localparam int CCSDS_W = 128;
  localparam int CNT_W   = 24;
  localparam int LEN_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_RECV,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  // ceil(n/2) without a carry out of CNT_W bits, so n = 2^24-1 cannot wrap.
  function automatic logic [CNT_W-1:0] words256(input logic [CNT_W-1:0] n);
    return (n >> 1) + {{(CNT_W-1){1'b0}}, n[0]};
  endfunction

endpackage

// File: rtl/sync_fifo_256.sv
// Show-ahead synchronous FIFO for 256-bit DDR beats; exposes its fill count so the
// requester can reserve room for a whole burst before asking for it.
module sync_fifo_256 #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_wr   = wr_en && (count != (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers and fill count; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conversion_in.sv
// Fetches one stored CCSDS code stream from DDR in bursts and hands it to the decoder
// as 128-bit words: burst requester FSM, beat buffer and a half-select output register.
module conversion_in
  import conversion_pkg::*;
#(
  parameter int BURST_WORDS = 32,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    code_cnt,
  output logic                busy,
  output logic                ddr_rd_req,
  input  logic                ddr_rd_grant,
  output logic [LEN_W-1:0]    ddr_rd_len,
  input  logic                ddr_rd_valid,
  input  logic [DDR_W-1:0]    ddr_rd_data,
  output logic                ccsds_data_valid,
  input  logic                ccsds_data_ready,
  output logic [CCSDS_W-1:0]  ccsds_data,
  output logic                ccsds_last,
  output logic                ccsds_finish_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (AW + 1 > LEN_W) ? AW + 1 : LEN_W;
  localparam logic [LEN_W-1:0] BURST_LEN = LEN_W'(BURST_WORDS);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   code_cnt_l;
  logic [CNT_W-1:0]   requested;
  logic [CNT_W-1:0]   ld_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [LEN_W-1:0]   burst_len;
  logic [LEN_W-1:0]   beat_cnt;
  logic               err_sticky;

  logic               vld_p1;
  logic [CCSDS_W-1:0] data_p1;
  logic               half_sel;

  logic [DDR_W-1:0]   fifo_rd_data;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic               fifo_rd;

  logic [CNT_W-1:0]   req_left;
  logic [LEN_W-1:0]   len_nxt;
  logic [AW:0]        fifo_free;
  logic               room_ok;
  logic               beat_ok;
  logic               beat_last;
  logic               accept;
  logic               last_word;
  logic               can_load;
  logic               final_odd;

  // Burst sizing: what is left to request, capped at one burst. Requests never overlap,
  // so when the FSM sits in CHECK there are no beats in flight and free space is exact.
  assign req_left  = words256(code_cnt_l) - requested;
  assign len_nxt   = (req_left < CNT_W'(BURST_WORDS)) ? req_left[LEN_W-1:0] : BURST_LEN;
  assign fifo_free = (AW+1)'(FIFO_DEPTH) - fifo_count;
  assign room_ok   = CW'(fifo_free) >= CW'(len_nxt);

  // Only beats inside the granted burst are kept; anything else is dropped and flagged.
  assign beat_ok   = ddr_rd_valid && (state == ST_RECV) && (beat_cnt < burst_len);
  assign beat_last = beat_ok && (beat_cnt == burst_len - LEN_W'(1));

  // Output side: refill the register whenever it is empty or being drained this cycle.
  assign accept    = vld_p1 && ccsds_data_ready;
  assign last_word = vld_p1 && (out_cnt == code_cnt_l - CNT_W'(1));
  assign can_load  = (!vld_p1 || ccsds_data_ready) && !fifo_empty && (ld_cnt != code_cnt_l);
  assign final_odd = !half_sel && (ld_cnt == code_cnt_l - CNT_W'(1));
  assign fifo_rd   = can_load && (half_sel || final_odd);

  assign busy              = (state != ST_IDLE);
  assign ddr_rd_req        = (state == ST_REQ);
  assign ddr_rd_len        = burst_len;
  assign ccsds_data_valid  = vld_p1;
  assign ccsds_data        = data_p1;
  assign ccsds_last        = last_word;
  assign ccsds_finish_flag = (state == ST_FINISH);

  sync_fifo_256 #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (beat_ok),
    .wr_data (ddr_rd_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode for the fetch sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (code_cnt == '0) ? ST_FINISH : ST_CHECK;
      ST_CHECK: begin
        if (req_left == '0) state_nxt = ST_DRAIN;
        else if (room_ok)   state_nxt = ST_REQ;
      end
      ST_REQ:    if (ddr_rd_grant) state_nxt = ST_RECV;
      ST_RECV:   if (beat_last) state_nxt = ST_CHECK;
      ST_DRAIN:  if (accept && last_word) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Stream length, burst and beat bookkeeping plus the stray-beat error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_cnt_l <= '0;
      requested  <= '0;
      burst_len  <= '0;
      beat_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        code_cnt_l <= code_cnt;
        requested  <= '0;
      end
      if (state == ST_CHECK && req_left != '0 && room_ok) burst_len <= len_nxt;
      if (state == ST_REQ && ddr_rd_grant) begin
        requested <= requested + CNT_W'(burst_len);
        beat_cnt  <= '0;
      end else if (beat_ok) begin
        beat_cnt  <= beat_cnt + LEN_W'(1);
      end
      if (ddr_rd_valid && !beat_ok) err_sticky <= 1'b1;
    end
  end

  // Output register: lower half of each FIFO word first, then upper half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      half_sel <= 1'b0;
      ld_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        half_sel <= 1'b0;
        ld_cnt   <= '0;
        out_cnt  <= '0;
      end else begin
        if (can_load) begin
          vld_p1   <= 1'b1;
          data_p1  <= half_sel ? fifo_rd_data[DDR_W-1:CCSDS_W] : fifo_rd_data[CCSDS_W-1:0];
          half_sel <= !half_sel && !final_odd;
          ld_cnt   <= ld_cnt + CNT_W'(1);
        end else if (accept) begin
          vld_p1   <= 1'b0;
        end
        if (accept) out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conversion_in.sv
// Bench for conversion_in: a DDR responder model feeds numbered 128-bit words, the
// decoder side is driven with several ready patterns, and results are compared
// against the word sequence and burst split derived from code_cnt.
module tb_conversion_in;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [23:0]  code_cnt;
  logic         busy;
  logic         ddr_rd_req;
  logic         ddr_rd_grant;
  logic [7:0]   ddr_rd_len;
  logic         ddr_rd_valid;
  logic [255:0] ddr_rd_data;
  logic         ccsds_data_valid;
  logic         ccsds_data_ready;
  logic [127:0] ccsds_data;
  logic         ccsds_last;
  logic         ccsds_finish_flag;

  int errors = 0;
  int checks = 0;

  // DDR model controls (written by tests at posedge or between streams, read by model)
  int          stream_id = 0;
  logic [31:0] cur_tag = 32'h0;
  int          grant_dly = 2;
  bit          m_abort = 0;
  bit          inj_beat = 0;
  bit          spur = 0;
  // DDR model state/observations
  int          m_st, m_wait, m_left, m_idx, m_sid;
  logic [7:0]  m_len;
  bit          spur_done;
  int          beats_sent;
  int          len_bad;
  int          len_q[$];

  // Runner observations
  logic [127:0] rx_q[$];
  int fin_cnt, fin_cyc, last_cnt, last_pos, acc_last_cyc, stab_err;
  bit req_seen, timeout;
  logic busy_after;

  conversion_in dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .code_cnt          (code_cnt),
    .busy              (busy),
    .ddr_rd_req        (ddr_rd_req),
    .ddr_rd_grant      (ddr_rd_grant),
    .ddr_rd_len        (ddr_rd_len),
    .ddr_rd_valid      (ddr_rd_valid),
    .ddr_rd_data       (ddr_rd_data),
    .ccsds_data_valid  (ccsds_data_valid),
    .ccsds_data_ready  (ccsds_data_ready),
    .ccsds_data        (ccsds_data),
    .ccsds_last        (ccsds_last),
    .ccsds_finish_flag (ccsds_finish_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [31:0] tag, input int i);
    logic [31:0] iv;
    iv = i;
    return {tag, iv, ~iv, tag ^ (iv * 32'h9E3779B9)};
  endfunction

  function automatic logic [255:0] beat_word(input logic [31:0] tag, input int k);
    return {pat(tag, 2*k+1), pat(tag, 2*k)};
  endfunction

  // Index of first wrong received word, -1 when the whole stream matches.
  function automatic int first_bad(input int cnt);
    int n;
    n = (rx_q.size() < cnt) ? rx_q.size() : cnt;
    for (int i = 0; i < n; i++) if (rx_q[i] !== pat(cur_tag, i)) return i;
    if (rx_q.size() != cnt) return n;
    return -1;
  endfunction

  // Number of burst lengths that differ from min(32, remaining 256-bit words) splitting.
  function automatic int burst_err(input int cnt);
    int rem, idx, bad, l;
    rem = (cnt + 1) / 2; idx = 0; bad = 0;
    while (rem > 0) begin
      l = (rem < 32) ? rem : 32;
      if (idx >= len_q.size()) bad++;
      else if (len_q[idx] != l) bad++;
      idx++; rem -= l;
    end
    if (len_q.size() != idx) bad++;
    return bad;
  endfunction

  // DDR read-port model: answers each request with a grant, then len numbered beats.
  initial begin
    m_st = 0; m_wait = 0; m_left = 0; m_idx = 0; m_sid = 0; m_len = '0;
    spur_done = 0; beats_sent = 0; len_bad = 0;
    ddr_rd_grant = 1'b0; ddr_rd_valid = 1'b0; ddr_rd_data = '0;
    forever begin
      @(negedge clk);
      ddr_rd_grant = 1'b0;
      ddr_rd_valid = 1'b0;
      if (m_sid != stream_id) begin
        m_sid = stream_id; m_idx = 0; beats_sent = 0; len_bad = 0;
        len_q.delete(); m_st = 0; spur_done = 0;
      end
      if (m_abort) begin
        m_st = 0;
      end else if (inj_beat) begin
        ddr_rd_valid = 1'b1;
        ddr_rd_data  = {8{32'hDEADBEEF}};
      end else begin
        case (m_st)
          0: if (ddr_rd_req) begin
               m_len = ddr_rd_len; len_q.push_back(int'(ddr_rd_len));
               m_wait = grant_dly - 1; m_st = 1;
             end
          1: begin
               if (!ddr_rd_req || ddr_rd_len != m_len) len_bad++;
               if (m_wait <= 0) begin
                 ddr_rd_grant = 1'b1; m_left = int'(m_len); m_st = 2;
               end else m_wait--;
             end
          default: begin
               if (spur && !spur_done && m_left >= 2) begin
                 ddr_rd_grant = 1'b1; spur_done = 1;
               end
               if ($urandom_range(0, 3) != 0) begin
                 ddr_rd_valid = 1'b1;
                 ddr_rd_data  = beat_word(cur_tag, m_idx);
                 m_idx++; m_left--; beats_sent++;
                 if (m_left == 0) m_st = 0;
               end
             end
        endcase
      end
    end
  end

  // Runs one stream to its finish pulse and records what the decoder side saw.
  // rmode: 0 ready always, 1 ready one cycle in three, 2 random ready.
  task automatic run_stream(input int cnt, input int rmode, input int restart_at);
    bit prev_hold;
    logic [127:0] prev_data;
    int budget;
    bit done;
    stream_id++;
    cur_tag = $urandom;
    rx_q.delete();
    fin_cnt = 0; fin_cyc = -1; last_cnt = 0; last_pos = -1; acc_last_cyc = -100;
    stab_err = 0; req_seen = 0; timeout = 0; busy_after = 1'bx;
    prev_hold = 0; prev_data = '0; done = 0;
    budget = 60 * cnt + 200;
    @(negedge clk);
    code_cnt = cnt[23:0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (fin_cnt > 0 && cyc > fin_cyc) begin
        busy_after = busy; done = 1; break;
      end
      if (ccsds_finish_flag) begin fin_cnt++; fin_cyc = cyc; end
      if (ddr_rd_req) req_seen = 1;
      if (prev_hold && (!ccsds_data_valid || ccsds_data !== prev_data)) stab_err++;
      start    = (cyc == restart_at);
      code_cnt = (cyc == restart_at) ? cnt[23:0] + 24'd7 : cnt[23:0];
      case (rmode)
        0:       ccsds_data_ready = 1'b1;
        1:       ccsds_data_ready = (cyc % 3 == 0);
        default: ccsds_data_ready = $urandom_range(0, 1) != 0;
      endcase
      if (ccsds_data_valid && ccsds_data_ready) begin
        rx_q.push_back(ccsds_data);
        if (ccsds_last) begin
          last_cnt++; last_pos = rx_q.size() - 1; acc_last_cyc = cyc;
        end
      end
      prev_hold = ccsds_data_valid && !ccsds_data_ready;
      prev_data = ccsds_data;
      @(negedge clk);
    end
    start = 1'b0;
    ccsds_data_ready = 1'b0;
    if (!done) timeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; code_cnt = '0; ccsds_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ddr_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ddr_rd_req); end
    checks++; if (ccsds_data_valid !== 1'b0 || ccsds_data !== '0 || ccsds_last !== 1'b0 || ccsds_finish_flag !== 1'b0) begin
      errors++; $display("FAIL reset_out: valid=%b data=%h last=%b fin=%b want all 0", ccsds_data_valid, ccsds_data, ccsds_last, ccsds_finish_flag);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int fb, be;
    grant_dly = 2;
    run_stream(64, 0, 0);
    fb = first_bad(64); be = burst_err(64);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL t1_timeout: no finish pulse within budget"); end
    checks++; if (fb !== -1) begin errors++; $display("FAIL t1_words: first bad index %0d (got %0d words) want -1 (64 words)", fb, rx_q.size()); end
    checks++; if (len_q.size() !== 1 || be !== 0) begin errors++; $display("FAIL t1_bursts: got %0d bursts, %0d wrong, want 1 burst of 32", len_q.size(), be); end
    checks++; if (last_cnt !== 1 || last_pos !== 63) begin errors++; $display("FAIL t1_last: got count %0d at %0d want 1 at 63", last_cnt, last_pos); end
    checks++; if (fin_cnt !== 1 || fin_cyc !== acc_last_cyc + 1) begin errors++; $display("FAIL t1_finish: got %0d pulses at cycle %0d want 1 at %0d", fin_cnt, fin_cyc, acc_last_cyc + 1); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b want 0", busy_after); end
    checks++; if (len_bad !== 0) begin errors++; $display("FAIL t1_len_stable: got %0d unstable cycles want 0", len_bad); end
  endtask

  task automatic test_odd_length();
    int fb, be;
    grant_dly = $urandom_range(1, 4);
    run_stream(307, 2, 0);
    fb = first_bad(307); be = burst_err(307);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL t2_timeout: no finish pulse within budget"); end
    checks++; if (fb !== -1) begin errors++; $display("FAIL t2_words: first bad index %0d (got %0d words) want -1 (307 words)", fb, rx_q.size()); end
    checks++; if (be !== 0) begin errors++; $display("FAIL t2_bursts: got %0d wrong of %0d bursts want 0 wrong (32x4,26)", be, len_q.size()); end
    checks++; if (beats_sent !== 154) begin errors++; $display("FAIL t2_beats: got %0d want 154", beats_sent); end
    checks++; if (last_cnt !== 1 || last_pos !== 306) begin errors++; $display("FAIL t2_last: got count %0d at %0d want 1 at 306", last_cnt, last_pos); end
  endtask

  task automatic test_backpressure();
    int fb, be;
    grant_dly = 2;
    run_stream(200, 1, 0);
    fb = first_bad(200); be = burst_err(200);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL t3_timeout: no finish pulse within budget"); end
    checks++; if (fb !== -1) begin errors++; $display("FAIL t3_words: first bad index %0d (got %0d words) want -1 (200 words)", fb, rx_q.size()); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL t3_hold: got %0d unstable held words want 0", stab_err); end
    checks++; if (be !== 0) begin errors++; $display("FAIL t3_bursts: got %0d wrong of %0d bursts want 0", be, len_q.size()); end
    checks++; if (dut.err_sticky !== 1'b0) begin errors++; $display("FAIL t3_err: got %b want 0", dut.err_sticky); end
  endtask

  task automatic test_empty();
    run_stream(0, 0, 0);
    checks++; if (fin_cnt !== 1 || fin_cyc < 1 || fin_cyc > 2) begin errors++; $display("FAIL t4_finish: got %0d pulses at cycle %0d want 1 within 2 cycles", fin_cnt, fin_cyc); end
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL t4_req: got %b want 0", req_seen); end
    checks++; if (busy_after !== 1'b0 || rx_q.size() !== 0) begin errors++; $display("FAIL t4_idle: busy=%b words=%0d want 0/0", busy_after, rx_q.size()); end
  endtask

  task automatic test_ignored_events();
    int fb, be;
    grant_dly = 3;
    spur = 1;
    run_stream(150, 2, 40);
    spur = 0;
    fb = first_bad(150); be = burst_err(150);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL t5_timeout: no finish pulse within budget"); end
    checks++; if (fb !== -1) begin errors++; $display("FAIL t5_words: first bad index %0d (got %0d words) want -1 (150 words)", fb, rx_q.size()); end
    checks++; if (be !== 0 || fin_cnt !== 1) begin errors++; $display("FAIL t5_bursts: got %0d wrong bursts, %0d finish want 0, 1", be, fin_cnt); end
  endtask

  task automatic test_reset_mid_stream();
    int fb;
    int w;
    stream_id++;
    cur_tag = $urandom;
    grant_dly = 2;
    @(negedge clk);
    code_cnt = 24'd128; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (beats_sent < 10 && w < 500) begin @(negedge clk); w++; end
    checks++; if (w >= 500) begin errors++; $display("FAIL t6_wait: got %0d beats want 10 before reset", beats_sent); end
    rst_n = 1'b0;
    @(posedge clk); m_abort = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ddr_rd_req !== 1'b0 || ccsds_data_valid !== 1'b0 || ccsds_data !== '0) begin
      errors++; $display("FAIL t6_in_reset: busy=%b req=%b valid=%b data=%h want 0", busy, ddr_rd_req, ccsds_data_valid, ccsds_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); m_abort = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ccsds_data_valid !== 1'b0 || ccsds_finish_flag !== 1'b0) begin
      errors++; $display("FAIL t6_after_reset: busy=%b valid=%b fin=%b want 0", busy, ccsds_data_valid, ccsds_finish_flag);
    end
    run_stream(4, 0, 0);
    fb = first_bad(4);
    checks++; if (fb !== -1 || timeout !== 1'b0) begin errors++; $display("FAIL t6_words: first bad %0d (got %0d words, timeout %b) want -1 (4 words)", fb, rx_q.size(), timeout); end
    checks++; if (fin_cnt !== 1 || last_pos !== 3) begin errors++; $display("FAIL t6_finish: got %0d pulses, last at %0d want 1, 3", fin_cnt, last_pos); end
  endtask

  task automatic test_stray_beat();
    @(posedge clk); inj_beat = 1;
    @(posedge clk); inj_beat = 0;
    @(negedge clk);
    checks++; if (dut.err_sticky !== 1'b1 || ccsds_data_valid !== 1'b0) begin
      errors++; $display("FAIL stray_beat: err=%b valid=%b want 1/0", dut.err_sticky, ccsds_data_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dut.err_sticky !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b want 0", dut.err_sticky); end
  endtask

  task automatic test_random_streams();
    int cnt, fb, be;
    for (int r = 0; r < 3; r++) begin
      cnt = $urandom_range(1, 100);
      grant_dly = $urandom_range(1, 5);
      run_stream(cnt, 2, 0);
      fb = first_bad(cnt); be = burst_err(cnt);
      checks++; if (fb !== -1 || be !== 0 || timeout !== 1'b0) begin
        errors++; $display("FAIL rand_%0d: cnt=%0d first bad %0d, bad bursts %0d, timeout %b want -1/0/0", r, cnt, fb, be, timeout);
      end
      checks++; if (last_pos !== cnt - 1 || fin_cyc !== acc_last_cyc + 1) begin
        errors++; $display("FAIL rand_last_%0d: last at %0d fin cyc %0d want %0d, %0d", r, last_pos, fin_cyc, cnt - 1, acc_last_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_odd_length();
    test_backpressure();
    test_empty();
    test_ignored_events();
    test_reset_mid_stream();
    test_stray_beat();
    test_random_streams();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
